// File: rtl/av2_ref_pixel_server.sv
// -----------------------------------------------------------------------------
// av2_ref_pixel_server
//
// Answers single-pixel reference reads from motion compensation. Requests are
// queued in a small FIFO as absolute word addresses. They are issued to frame
// memory with a bounded number of reads in flight, and the pixels come back in
// request order. A flush throws away the queue and drains the reads that are
// still in flight, then pulses flush_done.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   ref_frame_base[31:0]        word base of the reference frame
//   ref_read_en, ref_read_addr  request strobe and pixel offset from the base
//   ref_read_ready              request accepted when ref_read_en is also high
//   ref_pixel_data[9:0]         returned pixel (holds its value between pulses)
//   ref_pixel_valid             one-cycle pulse per returned pixel
//   flush / flush_done          abort everything / drain-complete pulse
//   drop_err                    sticky: a strobe arrived while not ready
//   mem_req, mem_addr, mem_gnt  memory read issue handshake
//   mem_rvalid, mem_rdata       in-order read data; only bits [9:0] are used
//
// Optional feature macro: AV2_REF_LAST_HIT_EN
//   When this macro is defined, the block keeps the last returned (address,
//   pixel) pair. A repeated read that arrives while the block is idle is
//   answered from that pair without a memory access.
// -----------------------------------------------------------------------------
module av2_ref_pixel_server #(
  parameter int REQ_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ref_frame_base,
  input  logic        ref_read_en,
  input  logic [31:0] ref_read_addr,
  output logic        ref_read_ready,
  output logic [9:0]  ref_pixel_data,
  output logic        ref_pixel_valid,
  input  logic        flush,
  output logic        flush_done,
  output logic        drop_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata
);

  localparam int PW = $clog2(REQ_DEPTH);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;

  state_e        state_q;
  logic [31:0]   fifo_q [REQ_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic [3:0]    outst_q, outst_d;
  logic          pix_valid_q, flush_done_q, drop_err_q;
  logic [9:0]    pix_data_q;

  logic          fifo_full, fifo_empty;
  logic          accept, push, pop, ret, hit_take;
  logic [31:0]   req_addr;
  logic          unused_rdata_hi;

  assign unused_rdata_hi = ^mem_rdata[15:10];

  // The 32-bit add wraps modulo 2^32 by construction.
  assign req_addr   = ref_frame_base + ref_read_addr;
  assign fifo_full  = (count_q == (PW+1)'(REQ_DEPTH));
  assign fifo_empty = (count_q == '0);

  assign ref_read_ready = (state_q == RUN) && !fifo_full;
  // A strobe in the same cycle as a flush is dropped: the flush clears the queue anyway.
  assign accept   = ref_read_en && ref_read_ready && !flush;
  assign push     = accept && !hit_take;

  assign mem_req  = (state_q == RUN) && !fifo_empty && (outst_q < 4'(MAX_OUTSTANDING));
  assign mem_addr = fifo_q[rd_ptr_q];
  assign pop      = mem_req && mem_gnt;
  // Read data that arrives with nothing in flight is stale (for example, after a reset), so it is ignored.
  assign ret      = mem_rvalid && (outst_q != 4'd0);

  assign outst_d  = outst_q + 4'(pop) - 4'(ret);
  assign count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);

  assign ref_pixel_valid = pix_valid_q;
  assign ref_pixel_data  = pix_data_q;
  assign flush_done      = flush_done_q;
  assign drop_err        = drop_err_q;

`ifdef AV2_REF_LAST_HIT_EN
  // This queue holds the addresses of reads in flight, so that each return can be paired with its address.
  logic [31:0] infl_q [16];
  logic [3:0]  infl_wr_q, infl_rd_q;
  logic        hit_valid_q;
  logic [31:0] hit_addr_q;
  logic [9:0]  hit_pix_q;

  assign hit_take = accept && fifo_empty && (outst_q == 4'd0) && hit_valid_q &&
                    (hit_addr_q == req_addr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      infl_wr_q   <= '0;
      infl_rd_q   <= '0;
      hit_valid_q <= 1'b0;
      hit_addr_q  <= '0;
      hit_pix_q   <= '0;
    end else begin
      if (pop) begin
        infl_q[infl_wr_q] <= mem_addr;
        infl_wr_q         <= infl_wr_q + 4'd1;
      end
      if (ret) infl_rd_q <= infl_rd_q + 4'd1;
      // Data that returns during a drain belongs to an aborted context and must not refill the register.
      if (state_q == RUN && flush) begin
        hit_valid_q <= 1'b0;
      end else if (state_q == RUN && ret) begin
        hit_valid_q <= 1'b1;
        hit_addr_q  <= infl_q[infl_rd_q];
        hit_pix_q   <= mem_rdata[9:0];
      end
    end
  end
`else
  assign hit_take = 1'b0;
`endif

  // NOTE: registered state uses non-blocking assignments only; the FIFO storage
  // array is deliberately left out of reset because the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= req_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      outst_q      <= '0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      flush_done_q <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      pix_valid_q  <= 1'b0;
      flush_done_q <= 1'b0;
      outst_q      <= outst_d;
      if (ref_read_en && !ref_read_ready) drop_err_q <= 1'b1;

      case (state_q)
        RUN: begin
          if (flush) begin
            state_q  <= DRAIN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
          end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push);
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            count_q  <= count_d;
            if (ret) begin
              pix_valid_q <= 1'b1;
              pix_data_q  <= mem_rdata[9:0];
            end
`ifdef AV2_REF_LAST_HIT_EN
            else if (hit_take) begin
              pix_valid_q <= 1'b1;
              pix_data_q  <= hit_pix_q;
            end
`endif
          end
        end
        DRAIN: begin
          if (outst_q == 4'd0) begin
            state_q      <= RUN;
            flush_done_q <= 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_av2_ref_pixel_server.sv
module tb_av2_ref_pixel_server;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ref_frame_base, ref_read_addr, mem_addr;
  logic        ref_read_en, ref_read_ready, ref_pixel_valid;
  logic [9:0]  ref_pixel_data;
  logic        flush, flush_done, drop_err, mem_req, mem_gnt, mem_rvalid;
  logic [15:0] mem_rdata;

  av2_ref_pixel_server dut (
    .clk(clk), .rst_n(rst_n), .ref_frame_base(ref_frame_base),
    .ref_read_en(ref_read_en), .ref_read_addr(ref_read_addr),
    .ref_read_ready(ref_read_ready), .ref_pixel_data(ref_pixel_data),
    .ref_pixel_valid(ref_pixel_valid), .flush(flush), .flush_done(flush_done),
    .drop_err(drop_err), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;

  logic [9:0]  exp_pix[$];   // scoreboard: expected pixels in order
  logic [31:0] exp_addr[$];  // scoreboard: expected memory issue addresses
  pend_t       pend[$];      // memory model: granted, not yet returned
  int          cyc = 0;
  int          lat = 2;      // cycles from grant to rvalid
  int          allow = -1;   // responses allowed: -1 = unlimited, 0 = withheld
  int          n_grants = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: the returned word is {6'h3F, addr[9:0]^10'h126}. The upper bits must be ignored by the DUT.
  always @(negedge clk) begin
    pend_t p;
    cyc++;
    if (rst_n === 1'b1 && mem_req === 1'b1 && mem_gnt) begin
      n_grants++;
      if (exp_addr.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_mem_req: got addr 0x%0h expected none", mem_addr);
      end else begin
        check("mem_addr", mem_addr, exp_addr.pop_front());
      end
      pend.push_back('{due: cyc + lat, addr: mem_addr});
    end
    if (pend.size() > 0 && pend[0].due <= cyc && allow != 0) begin
      p = pend.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata  = {6'h3F, p.addr[9:0] ^ 10'h126};
      if (allow > 0) allow--;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 16'h0BAD;
    end
  end

  // Monitor: each output pixel pulse pops the scoreboard.
  always @(negedge clk) begin
    if (ref_pixel_valid === 1'b1) begin
      if (exp_pix.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_pixel: got 0x%0h expected none", ref_pixel_data);
      end else begin
        check("pixel", {22'd0, ref_pixel_data}, {22'd0, exp_pix.pop_front()});
      end
    end
  end

  task automatic send(input logic [31:0] b, input logic [31:0] a, output logic acc, output logic drp);
    @(negedge clk);
    ref_frame_base = b; ref_read_addr = a; ref_read_en = 1'b1;
    #1 acc = ref_read_ready;
    drp = drop_err;
  endtask

  task automatic idle();
    @(negedge clk);
    ref_read_en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk); #2;
      if (exp_pix.size() == 0 && exp_addr.size() == 0 && pend.size() == 0) break;
    end
    check({name, "_drained"}, 32'(i < 300), 32'd1);
  endtask

  task automatic one_read(input string name, input logic [31:0] b, input logic [31:0] a,
                          input logic [31:0] ea, input logic [9:0] ep);
    logic acc, drp;
    exp_addr.push_back(ea);
    exp_pix.push_back(ep);
    send(b, a, acc, drp);
    idle();
    check({name, "_accept"}, 32'(acc), 32'd1);
    wait_drain(name);
  endtask

  initial begin
    logic acc, drp;
    int   g0, i;
    rst_n = 1'b0; ref_read_en = 1'b0; flush = 1'b0; mem_gnt = 1'b1;
    ref_frame_base = '0; ref_read_addr = '0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_pixel_valid", 32'(ref_pixel_valid), 32'd0);
    check("rst_flush_done", 32'(flush_done), 32'd0);
    check("rst_drop_err", 32'(drop_err), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #2;
    check("rst_ready", 32'(ref_read_ready), 32'd1);

    // 1: single read. 0x1005 -> data 0x005^0x126 = 0x123.
    one_read("single", 32'h1000, 32'd5, 32'h1005, 10'h123);

    // 5: address wrap. 0xFFFFFFFE+3 -> 0x00000001, data 0x127.
    one_read("wrap", 32'hFFFF_FFFE, 32'd3, 32'h0000_0001, 10'h127);

    // Flush together with a strobe: no accept, no drop_err, done two cycles later.
    g0 = n_grants;
    @(negedge clk);
    ref_frame_base = 32'h4000; ref_read_addr = '0; ref_read_en = 1'b1; flush = 1'b1;
    @(negedge clk);
    ref_read_en = 1'b0; flush = 1'b0;
    #2;
    check("flush0_ready_drain", 32'(ref_read_ready), 32'd0);
    check("flush0_done_early", 32'(flush_done), 32'd0);
    @(negedge clk); #2;
    check("flush0_done", 32'(flush_done), 32'd1);
    check("flush0_ready_back", 32'(ref_read_ready), 32'd1);
    @(negedge clk); #2;
    check("flush0_done_pulse", 32'(flush_done), 32'd0);
    check("flush0_drop_err", 32'(drop_err), 32'd0);
    check("flush0_no_issue", 32'(n_grants - g0), 32'd0);

    // 2: backpressure. Four requests fit; strobe 5 is dropped and drop_err follows.
    mem_gnt = 1'b0;
    exp_addr.push_back(32'h2000); exp_addr.push_back(32'h2001);
    exp_addr.push_back(32'h2002); exp_addr.push_back(32'h2003);
    exp_pix.push_back(10'h126); exp_pix.push_back(10'h127);
    exp_pix.push_back(10'h124); exp_pix.push_back(10'h125);
    for (i = 0; i < 6; i++) begin
      send(32'h2000, 32'(i), acc, drp);
      check($sformatf("bp_accept%0d", i), 32'(acc), 32'(i < 4));
      check($sformatf("bp_drop_before%0d", i), 32'(drp), 32'(i >= 5));
    end
    idle();
    mem_gnt = 1'b1;
    wait_drain("bp");
    check("bp_drop_sticky", 32'(drop_err), 32'd1);

    // 3: outstanding cap. With responses withheld, only 4 reads are issued.
    g0 = n_grants;
    allow = 0;
    for (i = 0; i < 6; i++) exp_addr.push_back(32'h3000 + 32'(i));
    exp_pix.push_back(10'h126); exp_pix.push_back(10'h127); exp_pix.push_back(10'h124);
    exp_pix.push_back(10'h125); exp_pix.push_back(10'h122); exp_pix.push_back(10'h123);
    for (i = 0; i < 6; i++) begin
      send(32'h3000, 32'(i), acc, drp);
      check($sformatf("cap_accept%0d", i), 32'(acc), 32'd1);
    end
    idle();
    repeat (5) @(negedge clk);
    #2;
    check("cap_issued", 32'(n_grants - g0), 32'd4);
    check("cap_req_low", 32'(mem_req), 32'd0);
    allow = 1;
    repeat (5) @(negedge clk);
    #2;
    check("cap_one_more", 32'(n_grants - g0), 32'd5);
    check("cap_req_low2", 32'(mem_req), 32'd0);
    allow = -1;
    wait_drain("cap");

    // 4: flush with 3 reads in flight and 2 queued. No pixels and no new issues are expected.
    g0 = n_grants;
    allow = 0;
    for (i = 0; i < 3; i++) exp_addr.push_back(32'h5000 + 32'(i));
    for (i = 0; i < 3; i++) send(32'h5000, 32'(i), acc, drp);
    idle();
    repeat (3) @(negedge clk);
    mem_gnt = 1'b0;
    for (i = 3; i < 5; i++) begin
      send(32'h5000, 32'(i), acc, drp);
      check($sformatf("fl_queue_accept%0d", i), 32'(acc), 32'd1);
    end
    idle();
    @(negedge clk); #2;
    check("fl_in_flight", 32'(n_grants - g0), 32'd3);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; mem_gnt = 1'b1;
    #2;
    check("fl_ready_low", 32'(ready_or_req(1'b1)), 32'd0);
    check("fl_req_low", 32'(ready_or_req(1'b0)), 32'd0);
    allow = -1;
    for (i = 0; i < 50; i++) begin
      @(negedge clk); #2;
      if (flush_done === 1'b1) break;
    end
    check("fl_done_seen", 32'(i < 50), 32'd1);
    check("fl_ready_back", 32'(ref_read_ready), 32'd1);
    check("fl_responses_used", 32'(pend.size()), 32'd0);
    repeat (3) @(negedge clk);
    #2;
    check("fl_no_new_issue", 32'(n_grants - g0), 32'd3);

    // Reset in the middle of a transfer: the stale returns after reset must be ignored.
    allow = 0;
    exp_addr.push_back(32'h6000); exp_addr.push_back(32'h6001);
    send(32'h6000, 32'd0, acc, drp);
    send(32'h6000, 32'd1, acc, drp);
    idle();
    repeat (4) @(negedge clk);
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("rst2_drop_clear", 32'(drop_err), 32'd0);
    check("rst2_req_low", 32'(mem_req), 32'd0);
    mem_gnt = 1'b1;
    allow = -1;
    wait_drain("rst2_stale");
    one_read("rst2_after", 32'h6000, 32'd9, 32'h6009, 10'h12F);

`ifdef AV2_REF_LAST_HIT_EN
    // 6: repeated address is served from the hit register until a flush.
    g0 = n_grants;
    one_read("hit_first", 32'h0, 32'd7, 32'h7, 10'h121);
    repeat (3) @(negedge clk);
    exp_pix.push_back(10'h121);
    send(32'h0, 32'd7, acc, drp);
    idle();
    wait_drain("hit_second");
    check("hit_one_issue", 32'(n_grants - g0), 32'd1);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    repeat (3) @(negedge clk);
    one_read("hit_after_flush", 32'h0, 32'd7, 32'h7, 10'h121);
    check("hit_reissue", 32'(n_grants - g0), 32'd2);
`endif

    repeat (5) @(negedge clk);
    #2;
    check("end_pix_queue", 32'(exp_pix.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  function automatic logic ready_or_req(input logic sel_ready);
    return sel_ready ? ref_read_ready : mem_req;
  endfunction

endmodule
